cache_mem_arbiter: RTL

//  Sits between the I-cache and D-cache fill FSMs and the single shared pipelined main memory.

---
 rtl/cache_mem_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared pipelined main memory between the I-fill and D-fill FSMs.
// Optional build macro ARB_ROUND_ROBIN_EN alternates I/D on simultaneous fill requests.
module cache_mem_arbiter #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_request,
  input  logic [ADDR_W-1:0] i_mem_address,
  input  logic              i_fsm_busy,
  output logic              i_memory_stall,
  output logic [DATA_W-1:0] i_data,
  output logic              i_data_valid,
  input  logic              d_mem_request,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic              d_fsm_busy,
  input  logic              d_wr_request,
  input  logic [ADDR_W-1:0] d_wr_address,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_memory_stall,
  output logic [DATA_W-1:0] d_data,
  output logic              d_data_valid,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_data_valid
);

  typedef enum logic [2:0] {IDLE, OWN_I, OWN_D, WRITE, DRAIN} state_t;

  state_t state, next_state;

  logic [MEM_LATENCY-1:0] tag_valid;
  logic [MEM_LATENCY-1:0] tag_owner;

  logic              i_active, d_fill_active, d_active;
  logic              drain_needed, d_wins_tie;
  logic              rd_en, wr_en, rd_owner_d;
  logic              i_stall_c, d_stall_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;
  logic              head_i, head_d;

  assign i_active      = i_mem_request | i_fsm_busy;
  assign d_fill_active = d_mem_request | d_fsm_busy;
  assign d_active      = d_fill_active | d_wr_request;

  // The head entry is delivered this cycle, so only younger entries keep us draining
  assign drain_needed = |tag_valid[MEM_LATENCY-2:0];

`ifdef ARB_ROUND_ROBIN_EN
  logic last_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d <= 1'b0;
    end else if (state == IDLE && next_state == OWN_I) begin
      last_d <= 1'b0;
    end else if (state == IDLE && next_state == OWN_D) begin
      last_d <= 1'b1;
    end
  end

  assign d_wins_tie = ~last_d;
`else
  assign d_wins_tie = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      state     <= next_state;
      tag_valid <= {tag_valid[MEM_LATENCY-2:0], rd_en};
      tag_owner <= {tag_owner[MEM_LATENCY-2:0], rd_owner_d};
    end
  end

  always_comb begin
    next_state = state;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    rd_owner_d = 1'b0;
    i_stall_c  = 1'b0;
    d_stall_c  = 1'b0;
    addr_c     = '0;
    wdata_c    = '0;
    case (state)
      IDLE: begin
        if (d_wr_request) begin
          wr_en      = 1'b1;
          addr_c     = d_wr_address;
          wdata_c    = d_wr_data;
          i_stall_c  = i_active;
          next_state = WRITE;
        end else if (d_fill_active && (!i_active || d_wins_tie)) begin
          rd_en      = d_mem_request;
          rd_owner_d = 1'b1;
          addr_c     = d_mem_request ? d_mem_address : '0;
          i_stall_c  = i_active;
          next_state = OWN_D;
        end else if (i_active) begin
          rd_en      = i_mem_request;
          addr_c     = i_mem_request ? i_mem_address : '0;
          next_state = OWN_I;
        end
      end
      OWN_I: begin
        rd_en     = i_mem_request;
        addr_c    = i_mem_request ? i_mem_address : '0;
        d_stall_c = d_active;
        if (!i_mem_request && !i_fsm_busy) begin
          next_state = drain_needed ? DRAIN : IDLE;
        end
      end
      OWN_D: begin
        // A store cannot interleave with our own fill; it retries from IDLE
        if (d_wr_request) begin
          d_stall_c = 1'b1;
        end else begin
          rd_en      = d_mem_request;
          rd_owner_d = 1'b1;
          addr_c     = d_mem_request ? d_mem_address : '0;
        end
        i_stall_c = i_active;
        if (!d_mem_request && !d_fsm_busy) begin
          next_state = drain_needed ? DRAIN : IDLE;
        end
      end
      WRITE: begin
        i_stall_c  = i_active;
        d_stall_c  = d_active;
        next_state = drain_needed ? DRAIN : IDLE;
      end
      DRAIN: begin
        i_stall_c = i_active;
        d_stall_c = d_active;
        if (!drain_needed) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Gate with rst_n so outputs drop immediately, even from the combinational IDLE grant path
  assign mem_enable     = rst_n & (rd_en | wr_en);
  assign mem_wr         = rst_n & wr_en;
  assign mem_address    = rst_n ? addr_c : '0;
  assign mem_data_in    = rst_n ? wdata_c : '0;
  assign i_memory_stall = rst_n & i_stall_c;
  assign d_memory_stall = rst_n & d_stall_c;

  assign head_i       = tag_valid[MEM_LATENCY-1] & ~tag_owner[MEM_LATENCY-1];
  assign head_d       = tag_valid[MEM_LATENCY-1] &  tag_owner[MEM_LATENCY-1];
  assign i_data_valid = mem_data_valid & head_i;
  assign d_data_valid = mem_data_valid & head_d;
  assign i_data       = i_data_valid ? mem_data_out : '0;
  assign d_data       = d_data_valid ? mem_data_out : '0;

endmodule
